axi_read_arbiter: RTL and testbench

- Shares the single AXI read channel (AR + R) among three requesters: icache (index 0), dcache (index 1) and uncache (index 2).
- Arbitrates between them, issues one burst at a time, and steers the returned beats to the granted requester.
- Sits between the cache/uncache miss logic and the AXI master port.
- Runs only on the read side; the write channel is handled by a separate block.

---
 rtl/axi_read_arbiter.sv | 141 ++++++++++++++
 tb/tb_axi_read_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read channel among icache (0), dcache (1) and uncache (2).
// One burst is in flight at a time, and returned beats are steered to the granted requester.
module axi_read_arbiter #(
  parameter bit         FIXED_PRIO = 1'b0,
  parameter logic [3:0] ID_BASE    = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_valid,
  input  logic [95:0] req_addr,
  input  logic [11:0] req_len,
  input  logic [8:0]  req_size,
  output logic [2:0]  req_ready,
  output logic [2:0]  resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_last,
  output logic        resp_err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [2:0]  fsm_state
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // arvalid and the AR fields stay stable until arready, and the R side holds rready
  // high for the whole DATA phase.
  typedef enum logic [2:0] {IDLE = 3'b001, ADDR = 3'b010, DATA = 3'b100} state_t;

  state_t     state, state_nxt;
  logic [1:0] rr_ptr, cur, win, base;
  logic [3:0] beat_cnt;
  logic       err_acc, any_req, beat, beat_err;

  // Requester index (b + k) mod 3, where b <= 2 and k <= 3.
  function automatic logic [1:0] idx3(input logic [1:0] b, input logic [2:0] k);
    logic [2:0] s;
    s = {1'b0, b} + k;
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Walk the search order backwards so that the earliest requester in the order wins.
  always_comb begin
    base    = FIXED_PRIO ? 2'd0 : rr_ptr;
    any_req = |req_valid;
    win     = 2'd0;
    for (int k = 3; k >= 1; k--)
      if (req_valid[idx3(base, 3'(k))]) win = idx3(base, 3'(k));
  end

  assign beat     = (state == DATA) && rvalid && rready;
  assign beat_err = (rresp != 2'b00) || (rid != arid) || (rlast && (beat_cnt != arlen));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (arvalid && arready) state_nxt = DATA;
      DATA:    if (beat && rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      req_ready  <= 3'b000;
      resp_valid <= 3'b000;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;
      araddr     <= 32'h0;
      arlen      <= 4'h0;
      arid       <= 4'h0;
      arsize     <= 3'b010;
      resp_data  <= 32'h0;
      rr_ptr     <= 2'd2;
      cur        <= 2'd0;
      beat_cnt   <= 4'h0;
      err_acc    <= 1'b0;
    end else begin
      req_ready  <= 3'b000;
      resp_valid <= 3'b000;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: if (any_req) begin
          araddr    <= req_addr[{win, 5'b00000} +: 32];
          arlen     <= req_len[{win, 2'b00} +: 4];
          arsize    <= req_size[win * 3 +: 3];
          arid      <= ID_BASE + {2'b00, win};
          arvalid   <= 1'b1;
          req_ready <= 3'b001 << win;
          cur       <= win;
          beat_cnt  <= 4'h0;
          err_acc   <= 1'b0;
        end
        ADDR: if (arready) begin
          arvalid <= 1'b0;
          araddr  <= 32'h0;
          rready  <= 1'b1;
        end
        DATA: if (beat) begin
          resp_data  <= rdata;
          resp_valid <= 3'b001 << cur;
          resp_last  <= rlast;
          beat_cnt   <= beat_cnt + 4'h1;
          err_acc    <= err_acc | beat_err;
          resp_err   <= err_acc | beat_err;
          if (rlast) begin
            rready <= 1'b0;
            rr_ptr <= cur;
          end
        end
        default: ;
      endcase
    end
  end

  assign arburst   = 2'b01;
  assign arlock    = 2'b00;
  assign arcache   = 4'h0;
  assign arprot    = 3'h0;
  assign fsm_state = state;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a round-robin instance and a fixed-priority instance
// share all inputs; use_fix selects which instance's outputs are checked.
module tb_axi_read_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]  req_valid;
  logic [95:0] req_addr;
  logic [11:0] req_len;
  logic [8:0]  req_size;
  logic        arready, rlast, rvalid;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  logic [2:0]  req_ready, resp_valid, arsize, arprot, fsm_state;
  logic [31:0] resp_data, araddr;
  logic        resp_last, resp_err, arvalid, rready;
  logic [3:0]  arid, arlen, arcache;
  logic [1:0]  arburst, arlock;

  logic [2:0]  f_req_ready, f_resp_valid, f_arsize, f_arprot, f_fsm_state;
  logic [31:0] f_resp_data, f_araddr;
  logic        f_resp_last, f_resp_err, f_arvalid, f_rready;
  logic [3:0]  f_arid, f_arlen, f_arcache;
  logic [1:0]  f_arburst, f_arlock;

  axi_read_arbiter #(.FIXED_PRIO(1'b0), .ID_BASE(4'h4)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_size(req_size), .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .fsm_state(fsm_state));

  axi_read_arbiter #(.FIXED_PRIO(1'b1), .ID_BASE(4'h0)) u_fix (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
    .req_size(req_size), .req_ready(f_req_ready), .resp_valid(f_resp_valid),
    .resp_data(f_resp_data), .resp_last(f_resp_last), .resp_err(f_resp_err), .arid(f_arid),
    .araddr(f_araddr), .arlen(f_arlen), .arsize(f_arsize), .arburst(f_arburst),
    .arlock(f_arlock), .arcache(f_arcache), .arprot(f_arprot), .arvalid(f_arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(f_rready), .fsm_state(f_fsm_state));

  logic        use_fix;
  logic [2:0]  c_req_ready, c_resp_valid, c_arsize, c_fsm_state;
  logic [31:0] c_resp_data, c_araddr;
  logic        c_resp_last, c_resp_err, c_arvalid, c_rready;
  logic [3:0]  c_arid, c_arlen;

  assign c_req_ready  = use_fix ? f_req_ready  : req_ready;
  assign c_resp_valid = use_fix ? f_resp_valid : resp_valid;
  assign c_arsize     = use_fix ? f_arsize     : arsize;
  assign c_fsm_state  = use_fix ? f_fsm_state  : fsm_state;
  assign c_resp_data  = use_fix ? f_resp_data  : resp_data;
  assign c_araddr     = use_fix ? f_araddr     : araddr;
  assign c_resp_last  = use_fix ? f_resp_last  : resp_last;
  assign c_resp_err   = use_fix ? f_resp_err   : resp_err;
  assign c_arvalid    = use_fix ? f_arvalid    : arvalid;
  assign c_rready     = use_fix ? f_rready     : rready;
  assign c_arid       = use_fix ? f_arid       : arid;
  assign c_arlen      = use_fix ? f_arlen      : arlen;

  logic [31:0] addr_t [3];
  logic [3:0]  len_t  [3];
  logic [2:0]  size_t [3];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant w, run the AR phase with ar_wait stall cycles, then return nbeats beats.
  // err_beat >= 0 puts SLVERR on that beat; abort_after > 0 stops after that many beats.
  task automatic run_burst(input int w, input int ar_wait, input int nbeats,
                           input int err_beat, input int abort_after);
    logic [3:0] idb;
    logic       exp_err;
    idb = use_fix ? 4'h0 : 4'h4;
    step();
    check("grant", 64'(c_req_ready), 64'(3'b001 << w));
    check("pulse_clear", 64'({c_resp_valid, c_resp_last}), 64'(0));
    check("ar_fields", 64'({c_arvalid, c_araddr, c_arlen, c_arid, c_arsize}),
          64'({1'b1, addr_t[w], len_t[w], idb + 4'(w), size_t[w]}));
    req_valid[w] = 1'b0;
    for (int i = 0; i < ar_wait; i++) begin
      arready = 1'b0;
      step();
      check("ar_hold", 64'({c_arvalid, c_araddr, c_arlen, c_arid, c_arsize, c_req_ready}),
            64'({1'b1, addr_t[w], len_t[w], idb + 4'(w), size_t[w], 3'b000}));
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("ar_done", 64'({c_arvalid, c_rready, c_araddr}), 64'({1'b0, 1'b1, 32'h0}));
    exp_err = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      rvalid = 1'b1;
      rdata  = 32'hD000_0000 + 32'(w * 256 + b);
      rid    = idb + 4'(w);
      rresp  = (b == err_beat) ? 2'b10 : 2'b00;
      rlast  = (b == nbeats - 1);
      if (b == err_beat) exp_err = 1'b1;
      if ((b == nbeats - 1) && (4'(b) != len_t[w])) exp_err = 1'b1;
      step();
      check("beat_valid", 64'(c_resp_valid), 64'(3'b001 << w));
      check("beat_data", 64'(c_resp_data), 64'(32'hD000_0000 + 32'(w * 256 + b)));
      check("beat_last", 64'(c_resp_last), 64'(b == nbeats - 1));
      if (b == nbeats - 1) begin
        check("resp_err", 64'(c_resp_err), 64'(exp_err));
        check("end_idle", 64'({c_fsm_state, c_rready}), 64'({3'b001, 1'b0}));
      end
      if (abort_after == b + 1) begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        return;
      end
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    addr_t[0] = 32'h1FC0_0000; len_t[0] = 4'd7; size_t[0] = 3'd2;
    addr_t[1] = 32'h8000_1040; len_t[1] = 4'd7; size_t[1] = 3'd1;
    addr_t[2] = 32'hA000_0200; len_t[2] = 4'd0; size_t[2] = 3'd2;
    req_addr  = {addr_t[2], addr_t[1], addr_t[0]};
    req_len   = {len_t[2], len_t[1], len_t[0]};
    req_size  = {size_t[2], size_t[1], size_t[0]};
    req_valid = 3'b000;
    arready   = 1'b0;
    rid       = 4'h0;
    rdata     = 32'h0;
    rresp     = 2'b00;
    rlast     = 1'b0;
    rvalid    = 1'b0;
    use_fix   = 1'b0;
    rst       = 1'b1;
    step();
    step();
    check("reset_regs", 64'({arvalid, rready, req_ready, resp_valid, resp_last, resp_err,
                             araddr, arlen, arid, arsize, fsm_state}),
          64'({1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0, 3'b010, 3'b001}));
    check("reset_data", 64'(resp_data), 64'(0));
    check("const_ar", 64'({arburst, arlock, arcache, arprot}),
          64'({2'b01, 2'b00, 4'h0, 3'h0}));
    rst = 1'b0;

    // Single icache burst of 8 beats.
    req_valid = 3'b001;
    run_burst(0, 0, 8, -1, -1);
    step();
    check("idle_quiet", 64'({fsm_state, arvalid, req_ready}), 64'({3'b001, 1'b0, 3'b000}));

    // Uncache single beat with arready held low for 5 cycles.
    req_valid = 3'b100;
    run_burst(2, 5, 1, -1, -1);

    // All three requesting, twice: round-robin gives 0, 1, 2 each time.
    req_valid = 3'b111;
    run_burst(0, 0, 8, -1, -1);
    run_burst(1, 0, 8, -1, -1);
    run_burst(2, 0, 1, -1, -1);
    req_valid = 3'b111;
    run_burst(0, 1, 8, -1, -1);
    run_burst(1, 0, 8, -1, -1);
    run_burst(2, 2, 1, -1, -1);

    // SLVERR on beat 3, clean burst, early rlast on beat 5, clean burst.
    req_valid = 3'b010;
    run_burst(1, 0, 8, 2, -1);
    req_valid = 3'b010;
    run_burst(1, 0, 8, -1, -1);
    req_valid = 3'b010;
    run_burst(1, 1, 5, -1, -1);
    req_valid = 3'b010;
    run_burst(1, 0, 8, -1, -1);

    // Reset after beat 2 of a dcache burst; rr_ptr must restart at 2.
    req_valid = 3'b010;
    run_burst(1, 0, 8, -1, 2);
    rst = 1'b1;
    step();
    check("rst_mid", 64'({arvalid, rready, resp_valid, fsm_state}),
          64'({1'b0, 1'b0, 3'b000, 3'b001}));
    rst = 1'b0;
    req_valid = 3'b111;
    run_burst(0, 0, 8, -1, -1);
    req_valid = 3'b000;

    // Fixed priority: dcache > uncache > icache.
    rst = 1'b1;
    step();
    rst = 1'b0;
    use_fix = 1'b1;
    req_valid = 3'b111;
    run_burst(1, 0, 8, -1, -1);
    run_burst(2, 0, 1, -1, -1);
    run_burst(0, 0, 8, -1, -1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
